// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage. Drives a combinational
// instruction ROM and hands fetched words to decode over valid/ready.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   imem_read_enable     ROM read strobe, high only on a fetch cycle
//   imem_address         ROM word index = pc[31:2]
//   imem_data            ROM data, same cycle as imem_address
//   redirect_valid/_pc   branch/jump redirect from execute
//   instr_valid/_ready   handshake towards decode
//   instr, instr_pc      fetched word and its byte address
//   halted               pc has left the populated ROM range
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_DEPTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_read_enable,
   output logic [31:0] imem_address,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        halted
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALT
   } state_t;

   localparam logic [31:0] DEPTH  = 32'(IMEM_DEPTH);
   localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_pc;
   logic        r_instr_valid;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;

   logic        w_in_range;
   logic        w_redirect;
   logic        w_fetch;
   logic        w_unused;

   // Redirect targets are forced word-aligned; the dropped bits are
   // intentionally ignored.
   assign w_unused   = ^redirect_pc[1:0];

   assign w_in_range = ({2'b00, r_pc[31:2]} < DEPTH);

   // A redirect seen in IDLE is ignored.
   assign w_redirect = redirect_valid && (r_state != S_IDLE);

   // Fetch only when the output slot is free or being drained.
   assign w_fetch = (r_state == S_RUN) && !redirect_valid &&
                    w_in_range &&
                    (!r_instr_valid || instr_ready);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: w_next = S_RUN;
         S_RUN: begin
            if (!redirect_valid && !w_in_range) begin
               w_next = S_HALT;
            end
         end
         S_HALT: begin
            if (redirect_valid) begin
               w_next = S_RUN;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      imem_read_enable = w_fetch;
      halted           = (r_state == S_HALT);
   end

   // PC and instruction output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= PC_RST;
         r_instr_valid <= 1'b0;
         r_instr       <= 32'h0;
         r_instr_pc    <= 32'h0;
      end else if (w_redirect) begin
         // Flush wins over any same-cycle accept.
         r_pc          <= {redirect_pc[31:2], 2'b00};
         r_instr_valid <= 1'b0;
      end else if (w_fetch) begin
         r_instr       <= imem_data;
         r_instr_pc    <= r_pc;
         r_instr_valid <= 1'b1;
         r_pc          <= r_pc + 32'd4;
      end else if (r_instr_valid && instr_ready) begin
         r_instr_valid <= 1'b0;
      end
   end

   assign imem_address = {2'b00, r_pc[31:2]};
   assign instr_valid  = r_instr_valid;
   assign instr        = r_instr;
   assign instr_pc     = r_instr_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an expected-instruction
// queue drained by a handshake monitor, plus direct control checks.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_ready;

   logic        re_a;
   logic [31:0] addr_a;
   logic [31:0] data_a;
   logic        valid_a;
   logic [31:0] instr_a;
   logic [31:0] ipc_a;
   logic        halt_a;

   logic        re_b;
   logic [31:0] addr_b;
   logic [31:0] data_b;
   logic        valid_b;
   logic [31:0] instr_b;
   logic [31:0] ipc_b;
   logic        halt_b;
   logic        redir_b = 1'b0;
   logic [31:0] rpc_b = 32'h0;
   logic        ready_b = 1'b1;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   // ROM word k holds 0x1000_0000 + k
   assign data_a = 32'h1000_0000 + addr_a;
   assign data_b = 32'h1000_0000 + addr_b;

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .IMEM_DEPTH(32)
   ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_read_enable(re_a),
      .imem_address    (addr_a),
      .imem_data       (data_a),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .instr_valid     (valid_a),
      .instr_ready     (instr_ready),
      .instr           (instr_a),
      .instr_pc        (ipc_a),
      .halted          (halt_a)
   );

   fetch_unit #(
      .RESET_PC  (32'h0000_0040),
      .IMEM_DEPTH(32)
   ) u_dut40 (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_read_enable(re_b),
      .imem_address    (addr_b),
      .imem_data       (data_b),
      .redirect_valid  (redir_b),
      .redirect_pc     (rpc_b),
      .instr_valid     (valid_b),
      .instr_ready     (ready_b),
      .instr           (instr_b),
      .instr_pc        (ipc_b),
      .halted          (halt_b)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Expected word for byte address pc is hand-derived: 0x1000_0000 + pc/4
   task automatic push(input logic [31:0] pc, input logic [31:0] word);
      q.push_back({word, pc});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted instruction must match the queue head
   always @(negedge clk) begin
      if (rst_n && valid_a && instr_ready && !redirect_valid) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL accept_unexpected: got pc %h instr %h, queue empty",
                     ipc_a, instr_a);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (ipc_a !== e.pc || instr_a !== e.word) begin
               errors++;
               $display("FAIL accept: got pc %h instr %h expected pc %h instr %h",
                        ipc_a, instr_a, e.pc, e.word);
            end
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks,
               errors + 1);
      $fatal(1);
   end

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      instr_ready    = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      chk("rst_valid", 32'(valid_a), 32'h0);
      chk("rst_instr", instr_a, 32'h0);
      chk("rst_ipc", ipc_a, 32'h0);
      chk("rst_halted", 32'(halt_a), 32'h0);
      chk("rst_re", 32'(re_a), 32'h0);
      chk("rst_addr", addr_a, 32'h0);
      chk("rst_addr_b", addr_b, 32'h10);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("idle_re", 32'(re_a), 32'h0);

      push(32'h0, 32'h1000_0000);
      push(32'h4, 32'h1000_0001);
      push(32'h8, 32'h1000_0002);

      tick();
      chk("run_re", 32'(re_a), 32'h1);
      chk("run_valid0", 32'(valid_a), 32'h0);
      tick();
      chk("first_valid", 32'(valid_a), 32'h1);
      chk("first_ipc", ipc_a, 32'h0);
      tick();
      tick();
      chk("pre_stall_ipc", ipc_a, 32'h8);

      // Backpressure for three cycles
      instr_ready = 1'b0;
      #1;
      chk("stall_re0", 32'(re_a), 32'h0);
      repeat (3) begin
         tick();
         chk("stall_instr", instr_a, 32'h1000_0002);
         chk("stall_ipc", ipc_a, 32'h8);
         chk("stall_valid", 32'(valid_a), 32'h1);
         chk("stall_re", 32'(re_a), 32'h0);
      end
      instr_ready = 1'b1;
      tick();
      chk("nogap_ipc", ipc_a, 32'hC);
      chk("nogap_valid", 32'(valid_a), 32'h1);

      // Redirect flushes 0xC; target 0x16 aligns down to 0x14
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0016;
      #1;
      chk("redir_re", 32'(re_a), 32'h0);
      tick();
      redirect_valid = 1'b0;
      chk("redir_flush", 32'(valid_a), 32'h0);
      push(32'h14, 32'h1000_0005);
      tick();
      chk("redir_ipc", ipc_a, 32'h14);
      chk("redir_instr", instr_a, 32'h1000_0005);

      for (int p = 'h18; p <= 'h74; p += 4) begin
         push(32'(p), 32'h1000_0000 + 32'(p / 4));
      end
      repeat (25) tick();
      chk("pre_7c_ipc", ipc_a, 32'h78);

      // Redirect in the cycle that would fetch 0x7C
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0060;
      #1;
      chk("redir7c_re", 32'(re_a), 32'h0);
      tick();
      redirect_valid = 1'b0;
      chk("redir7c_flush", 32'(valid_a), 32'h0);
      chk("redir7c_nohalt", 32'(halt_a), 32'h0);
      for (int p = 'h60; p <= 'h7C; p += 4) begin
         push(32'(p), 32'h1000_0000 + 32'(p / 4));
      end

      // Run off the end of the ROM
      repeat (8) tick();
      chk("last_ipc", ipc_a, 32'h7C);
      chk("last_instr", instr_a, 32'h1000_001F);
      chk("last_halted", 32'(halt_a), 32'h0);
      chk("oor_re", 32'(re_a), 32'h0);
      tick();
      chk("halt_rise", 32'(halt_a), 32'h1);
      chk("halt_drained", 32'(valid_a), 32'h0);
      repeat (3) begin
         tick();
         chk("halt_re", 32'(re_a), 32'h0);
         chk("halt_hold", 32'(halt_a), 32'h1);
      end

      // Redirect out of HALT
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      tick();
      redirect_valid = 1'b0;
      chk("unhalt", 32'(halt_a), 32'h0);
      chk("unhalt_valid", 32'(valid_a), 32'h0);
      tick();
      chk("unhalt_ipc", ipc_a, 32'h0);
      chk("unhalt_instr", instr_a, 32'h1000_0000);
      chk("unhalt_vld", 32'(valid_a), 32'h1);

      // Partial-cycle reset discards the in-flight instruction
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(valid_a), 32'h0);
      chk("async_instr", instr_a, 32'h0);
      chk("async_ipc", ipc_a, 32'h0);
      chk("async_halted", 32'(halt_a), 32'h0);
      chk("async_re", 32'(re_a), 32'h0);
      chk("async_addr_b", addr_b, 32'h10);
      chk("async_valid_b", 32'(valid_b), 32'h0);
      rst_n = 1'b1;

      push(32'h0, 32'h1000_0000);
      tick();
      chk("restart_valid_b", 32'(valid_b), 32'h0);
      chk("restart_re_b", 32'(re_b), 32'h1);
      tick();
      chk("restart_ipc", ipc_a, 32'h0);
      chk("restart_ipc_b", ipc_b, 32'h40);
      chk("restart_instr_b", instr_b, 32'h1000_0010);
      chk("restart_vld_b", 32'(valid_b), 32'h1);
      tick();
      instr_ready = 1'b0;
      chk("restart_next_ipc", ipc_a, 32'h4);
      tick();
      chk("queue_empty", 32'(q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks,
               errors);
      $finish;
   end

endmodule
